// File: rtl/result_demux_if.sv
// Handshake and data bundle between the subtracter result stream, the two
// destination consumers and the result demultiplexer.
interface result_demux_if #(
    parameter int unsigned CNT_W = 8
);
    logic             In_Valid;
    logic             In_Ready;
    logic [5:0]       Din;
    logic             sel;

    logic [3:0]       A_Out;
    logic             A_Ovf;
    logic             A_Valid;
    logic             A_Ready;

    logic [5:0]       B_Out;
    logic             B_Valid;
    logic             B_Ready;

    logic [CNT_W-1:0] Ovf_Count;

    // Demultiplexer side
    modport slave (
        input  In_Valid, Din, sel, A_Ready, B_Ready,
        output In_Ready, A_Out, A_Ovf, A_Valid, B_Out, B_Valid, Ovf_Count
    );

    // Producer / consumer side
    modport master (
        output In_Valid, Din, sel, A_Ready, B_Ready,
        input  In_Ready, A_Out, A_Ovf, A_Valid, B_Out, B_Valid, Ovf_Count
    );
endinterface

// File: rtl/result_demux.sv
// Registered 1-to-2 result demultiplexer: steers each accepted 6-bit word to a
// narrow 4-bit port (loss flagged and counted) or a full-width port.
module result_demux #(
    parameter int unsigned CNT_W = 8
) (
    input  logic          Clock,
    input  logic          Reset,
    result_demux_if.slave bus
);
    localparam int unsigned DIN_W  = 6;
    localparam int unsigned NARR_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [NARR_W-1:0] a_out_q;
    logic              a_ovf_q;
    logic              a_valid_q;
    logic [DIN_W-1:0]  b_out_q;
    logic              b_valid_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              in_ready_c;
    logic              load_a_c;
    logic              load_b_c;
    logic              drain_a_c;
    logic              drain_b_c;
    logic              ovf_c;

    // A slot may be refilled on the same edge its occupant is consumed
    always_comb begin
        in_ready_c = 1'b1;
        load_a_c   = 1'b0;
        load_b_c   = 1'b0;
        drain_a_c  = a_valid_q & bus.A_Ready;
        drain_b_c  = b_valid_q & bus.B_Ready;
        ovf_c      = bus.Din[5] | bus.Din[4];
        if (bus.sel) begin
            in_ready_c = !b_valid_q | bus.B_Ready;
        end else begin
            in_ready_c = !a_valid_q | bus.A_Ready;
        end
        load_a_c = bus.In_Valid & in_ready_c & !bus.sel;
        load_b_c = bus.In_Valid & in_ready_c &  bus.sel;
    end

    // Narrow port holding register; data stays put after drain
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            a_out_q   <= '0;
            a_ovf_q   <= 1'b0;
            a_valid_q <= 1'b0;
        end else if (load_a_c) begin
            a_out_q   <= bus.Din[NARR_W-1:0];
            a_ovf_q   <= ovf_c;
            a_valid_q <= 1'b1;
        end else if (drain_a_c) begin
            a_valid_q <= 1'b0;
        end
    end

    // Full-width port holding register
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            b_out_q   <= '0;
            b_valid_q <= 1'b0;
        end else if (load_b_c) begin
            b_out_q   <= bus.Din;
            b_valid_q <= 1'b1;
        end else if (drain_b_c) begin
            b_valid_q <= 1'b0;
        end
    end

    // Saturating count of narrow-port words that lost upper bits
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cnt_q <= '0;
        end else if (load_a_c && ovf_c && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.In_Ready  = in_ready_c;
    assign bus.A_Out     = a_out_q;
    assign bus.A_Ovf     = a_ovf_q;
    assign bus.A_Valid   = a_valid_q;
    assign bus.B_Out     = b_out_q;
    assign bus.B_Valid   = b_valid_q;
    assign bus.Ovf_Count = cnt_q;
endmodule

// File: tb/tb_result_demux.sv
// Scoreboard bench for result_demux: each port is modelled as a one-deep queue
// of expected words; a negedge monitor compares whatever the DUT presents.
module tb_result_demux;
    localparam int unsigned CNT_W   = 8;
    localparam int          CNT_SAT = (1 << CNT_W) - 1;

    logic Clock = 1'b0;
    logic rst_n = 1'b0;

    result_demux_if #(.CNT_W(CNT_W)) bus ();

    result_demux #(.CNT_W(CNT_W)) dut (
        .Clock (Clock),
        .Reset (rst_n),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        int data;
        int ovf;
    } exp_t;

    exp_t exp_a[$];
    exp_t exp_b[$];
    int   m_cnt = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a port accepts only when its expected slot is empty
    // (the monitor has already retired a word that the consumer is taking).
    initial begin
        forever begin
            @(posedge Clock or negedge rst_n);
            if (!rst_n) begin
                exp_a.delete();
                exp_b.delete();
                m_cnt = 0;
            end else if (bus.In_Valid === 1'b1) begin
                if (bus.sel == 1'b0 && exp_a.size() == 0) begin
                    exp_t e;
                    e.data = int'(bus.Din) % 16;
                    e.ovf  = (int'(bus.Din) >= 16) ? 1 : 0;
                    exp_a.push_back(e);
                    if (e.ovf == 1 && m_cnt < CNT_SAT) m_cnt++;
                end else if (bus.sel == 1'b1 && exp_b.size() == 0) begin
                    exp_t e;
                    e.data = int'(bus.Din);
                    e.ovf  = 0;
                    exp_b.push_back(e);
                end
            end
        end
    end

    // Monitor: compare presented outputs, retire words the consumer takes
    initial begin
        forever begin
            @(negedge Clock);
            if (rst_n) begin
                chk("a_valid", int'(bus.A_Valid), (exp_a.size() != 0) ? 1 : 0);
                if (exp_a.size() != 0) begin
                    chk("a_out", int'(bus.A_Out), exp_a[0].data);
                    chk("a_ovf", int'(bus.A_Ovf), exp_a[0].ovf);
                    if (bus.A_Ready) void'(exp_a.pop_front());
                end
                chk("b_valid", int'(bus.B_Valid), (exp_b.size() != 0) ? 1 : 0);
                if (exp_b.size() != 0) begin
                    chk("b_out", int'(bus.B_Out), exp_b[0].data);
                    if (bus.B_Ready) void'(exp_b.pop_front());
                end
                chk("in_ready", int'(bus.In_Ready),
                    bus.sel ? ((exp_b.size() == 0) ? 1 : 0) : ((exp_a.size() == 0) ? 1 : 0));
                chk("ovf_count", int'(bus.Ovf_Count), m_cnt);
            end
        end
    end

    task automatic drive(input logic v, input logic s, input logic [5:0] d,
                         input logic ar, input logic br);
        @(posedge Clock);
        #1;
        bus.In_Valid = v;
        bus.sel      = s;
        bus.Din      = d;
        bus.A_Ready  = ar;
        bus.B_Ready  = br;
    endtask

    // Assert reset between clock edges and check the immediate clear
    task automatic do_reset();
        @(posedge Clock);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_a_out",   int'(bus.A_Out), 0);
        chk("rst_a_ovf",   int'(bus.A_Ovf), 0);
        chk("rst_a_valid", int'(bus.A_Valid), 0);
        chk("rst_b_out",   int'(bus.B_Out), 0);
        chk("rst_b_valid", int'(bus.B_Valid), 0);
        chk("rst_count",   int'(bus.Ovf_Count), 0);
        bus.A_Ready  = 1'b0;
        bus.B_Ready  = 1'b0;
        bus.In_Valid = 1'b0;
        bus.sel      = 1'b0;
        #1;
        chk("rst_rdy_sel0", int'(bus.In_Ready), 1);
        bus.sel = 1'b1;
        #1;
        chk("rst_rdy_sel1", int'(bus.In_Ready), 1);
        @(posedge Clock);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        bus.In_Valid = 1'b0;
        bus.sel      = 1'b0;
        bus.Din      = '0;
        bus.A_Ready  = 1'b0;
        bus.B_Ready  = 1'b0;
        repeat (2) @(posedge Clock);
        #2;
        rst_n = 1'b1;

        // Preload both ports, then reset asynchronously
        drive(1, 0, 6'b110011, 0, 0);
        drive(1, 1, 6'b101010, 0, 0);
        drive(0, 0, 6'd0, 0, 0);
        chk("pre_a_valid", int'(bus.A_Valid), 1);
        chk("pre_b_valid", int'(bus.B_Valid), 1);
        do_reset();

        // Narrow path without loss
        drive(1, 0, 6'b001011, 1, 1);
        drive(0, 0, 6'd0, 1, 1);
        chk("narrow_out", int'(bus.A_Out), 11);
        drive(0, 0, 6'd0, 1, 1);
        chk("narrow_drained", int'(bus.A_Valid), 0);

        // Narrow path with loss
        drive(1, 0, 6'b110101, 1, 1);
        drive(0, 0, 6'd0, 1, 1);
        chk("loss_ovf", int'(bus.A_Ovf), 1);
        chk("loss_count1", int'(bus.Ovf_Count), 1);

        // Backpressure on A; B keeps flowing
        drive(1, 0, 6'h2A, 0, 1);
        repeat (3) drive(1, 0, 6'h15, 0, 1);
        chk("bp_in_ready", int'(bus.In_Ready), 0);
        chk("bp_a_hold", int'(bus.A_Out), 10);
        drive(1, 1, 6'b111111, 0, 1);
        drive(1, 1, 6'b000001, 0, 1);
        chk("bp_b_first", int'(bus.B_Out), 63);
        drive(0, 0, 6'd0, 1, 1);
        chk("bp_b_second", int'(bus.B_Out), 1);
        drive(0, 0, 6'd0, 1, 1);

        // Full throughput on B
        for (int i = 0; i < 16; i++) begin
            drive(1, 1, 6'(i), 1, 1);
            if (i > 0) begin
                chk("tput_b_valid", int'(bus.B_Valid), 1);
                chk("tput_b_out", int'(bus.B_Out), i - 1);
            end
        end
        drive(0, 0, 6'd0, 1, 1);
        chk("tput_b_last", int'(bus.B_Out), 15);
        drive(0, 0, 6'd0, 1, 1);

        // Reset mid-operation with count 5 and both ports full
        do_reset();
        for (int i = 0; i < 5; i++) drive(1, 0, 6'(32 + i), 1, 1);
        drive(1, 0, 6'h03, 0, 0);
        drive(1, 1, 6'h22, 0, 0);
        drive(0, 0, 6'd0, 0, 0);
        chk("mid_count5", int'(bus.Ovf_Count), 5);
        chk("mid_a_valid", int'(bus.A_Valid), 1);
        chk("mid_b_valid", int'(bus.B_Valid), 1);
        do_reset();
        drive(1, 0, 6'h07, 0, 1);
        drive(0, 0, 6'd0, 0, 1);
        chk("post_rst_first", int'(bus.A_Out), 7);
        drive(0, 0, 6'd0, 1, 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 4) != 0, 1'($urandom % 2), 6'($urandom % 64),
                  ($urandom % 3) != 0, ($urandom % 3) != 0);
        end
        drive(0, 0, 6'd0, 1, 1);
        drive(0, 0, 6'd0, 1, 1);

        // Saturation of the loss counter
        for (int i = 0; i < 300; i++) drive(1, 0, 6'b110101, 1, 1);
        drive(0, 0, 6'd0, 1, 1);
        chk("ovf_saturated", int'(bus.Ovf_Count), CNT_SAT);
        drive(0, 0, 6'd0, 1, 1);
        @(negedge Clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end
endmodule
